// File: rtl/ram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ram_ctrl_pkg
// Shared defaults and state encodings for the dual-port frame buffer
// controller (ram_dp_ctrl) and its address generator (ram_addr_gen).
//   AW_DEF / DW_DEF      : default address / data widths of buffer_ram_dp
//   MEM_DEPTH_DEF        : number of valid words (320x240 frame)
//   w_state_t            : write-port FSM states (capture idle / clear fill)
//   r_state_t            : read-port FSM states (idle / sequential scan)
// ---------------------------------------------------------------------------
package ram_ctrl_pkg;

   localparam int AW_DEF        = 17;
   localparam int DW_DEF        = 16;
   localparam int MEM_DEPTH_DEF = 76800;

   typedef enum logic {
      W_IDLE  = 1'b0,
      W_CLEAR = 1'b1
   } w_state_t;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_SCAN = 1'b1
   } r_state_t;

endpackage

// File: rtl/ram_addr_gen.sv
// ---------------------------------------------------------------------------
// ram_addr_gen
// Loadable up-counter over the frame buffer address range 0..MEM_DEPTH-1.
// The count saturates at MEM_DEPTH-1; wrap-around is done by the owner
// through clr.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset (count -> 0)
//   clr          : synchronous clear to 0 (highest priority)
//   load         : synchronous load of load_val (clamped to MEM_DEPTH-1)
//   load_val     : value for load
//   en           : advance by one (ignored at the last address)
//   count        : current address
//   last         : count == MEM_DEPTH-1
// ---------------------------------------------------------------------------
module ram_addr_gen #(
   parameter int AW        = 17,
   parameter int MEM_DEPTH = 76800
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          load,
   input  logic [AW-1:0] load_val,
   input  logic          en,
   output logic [AW-1:0] count,
   output logic          last
);

   localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_DEPTH - 1);

   assign last = (count == LAST_ADDR);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (load) begin
         count <= (load_val > LAST_ADDR) ? LAST_ADDR : load_val;
      end else if (en && !last) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/ram_dp_ctrl.sv
// ---------------------------------------------------------------------------
// ram_dp_ctrl
// Controller in front of the dual-port frame buffer buffer_ram_dp.
//   Write port: shared by the pixel-capture requester and an internal clear
//   (fill) engine that writes clr_color to every word 0..MEM_DEPTH-1.
//   Read port : driven by a sequential scan engine feeding the display path.
// All RAM-side outputs are registered. The two FSMs run independently.
//
// Handshake: a capture request transfers at a rising edge where
// wr_req && wr_ready. wr_ready is combinational and drops in the same cycle
// clr_start is raised, so a clear wins over a simultaneous capture; it stays
// low for the whole clear. The requester holds wr_addr/wr_data stable while
// wr_req is high and not yet accepted.
//
// Build option: define RAMCTL_CONT_SCAN_EN to let a scan continue into the
// next frame without a bubble when rd_start is high as the last address is
// issued. Undefined: every scan ends after one frame.
//
// Ports:
//   clk, rst_n                      : clock, async active-low reset
//   wr_req/wr_addr/wr_data/wr_ready : capture write request
//   clr_start/clr_color             : start whole-memory fill with colour
//   clr_busy/clr_done               : fill in progress / last-write pulse
//   rd_start/rd_en                  : start scan / advance (0 = stall)
//   rd_valid/rd_data/rd_frame_end   : scanned word stream, end-of-frame
//   ram_addr_in/ram_data_in/ram_regwrite : RAM write port
//   ram_addr_out/ram_regread/ram_data_out: RAM read port (1-cycle latency)
//   w_state_dbg / r_state_dbg       : current FSM states for observation
// ---------------------------------------------------------------------------
module ram_dp_ctrl
   import ram_ctrl_pkg::*;
#(
   parameter int AW        = AW_DEF,
   parameter int DW        = DW_DEF,
   parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   // capture write requester
   input  logic          wr_req,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   output logic          wr_ready,
   // clear engine control
   input  logic          clr_start,
   input  logic [DW-1:0] clr_color,
   output logic          clr_busy,
   output logic          clr_done,
   // scan engine
   input  logic          rd_start,
   input  logic          rd_en,
   output logic          rd_valid,
   output logic [DW-1:0] rd_data,
   output logic          rd_frame_end,
   // RAM side
   output logic [AW-1:0] ram_addr_in,
   output logic [DW-1:0] ram_data_in,
   output logic          ram_regwrite,
   output logic [AW-1:0] ram_addr_out,
   output logic          ram_regread,
   input  logic [DW-1:0] ram_data_out,
   // state observation
   output w_state_t      w_state_dbg,
   output r_state_t      r_state_dbg
);

   localparam logic [AW-1:0] DEPTH_A = AW'(MEM_DEPTH);

   // ------------------------------------------------------------------------
   // Write side
   // ------------------------------------------------------------------------
   w_state_t        w_state;
   w_state_t        w_state_nxt;
   logic            clr_cnt_clr;
   logic            clr_cnt_en;
   logic [AW-1:0]   clr_cnt;
   logic            clr_last;
   logic [DW-1:0]   clr_color_q;
   logic            cap_accept;
   logic            cap_in_range;

   assign wr_ready     = (w_state == W_IDLE) && !clr_start;
   assign cap_accept   = wr_req && wr_ready;
   // Out-of-range captures still complete the handshake but never reach RAM.
   assign cap_in_range = (wr_addr < DEPTH_A);
   assign w_state_dbg  = w_state;

   ram_addr_gen #(
      .AW        (AW),
      .MEM_DEPTH (MEM_DEPTH)
   ) u_clr_addr (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr_cnt_clr),
      .load     (1'b0),
      .load_val ('0),
      .en       (clr_cnt_en),
      .count    (clr_cnt),
      .last     (clr_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_state <= W_IDLE;
      end else begin
         w_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = w_state;
      clr_cnt_clr = 1'b0;
      clr_cnt_en  = 1'b0;
      case (w_state)
         W_IDLE: begin
            if (clr_start) begin
               w_state_nxt = W_CLEAR;
               clr_cnt_clr = 1'b1;
            end
         end
         W_CLEAR: begin
            // clr_start is deliberately not looked at here.
            clr_cnt_en = 1'b1;
            if (clr_last) begin
               w_state_nxt = W_IDLE;
            end
         end
         default: w_state_nxt = W_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clr_color_q  <= '0;
         ram_regwrite <= 1'b0;
         ram_addr_in  <= '0;
         ram_data_in  <= '0;
         clr_busy     <= 1'b0;
         clr_done     <= 1'b0;
      end else begin
         clr_busy <= (w_state_nxt == W_CLEAR);
         // Pulses alongside the final fill write on the RAM port.
         clr_done <= (w_state == W_CLEAR) && clr_last;

         if ((w_state == W_IDLE) && clr_start) begin
            clr_color_q <= clr_color;
         end

         if (w_state == W_CLEAR) begin
            ram_regwrite <= 1'b1;
            ram_addr_in  <= clr_cnt;
            ram_data_in  <= clr_color_q;
         end else if (cap_accept) begin
            ram_regwrite <= cap_in_range;
            ram_addr_in  <= wr_addr;
            ram_data_in  <= wr_data;
         end else begin
            ram_regwrite <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Read side
   // ------------------------------------------------------------------------
   r_state_t        r_state;
   r_state_t        r_state_nxt;
   logic            scan_clr;
   logic            scan_issue;
   logic [AW-1:0]   scan_cnt;
   logic            scan_last;
   logic            frame_pend;

   assign r_state_dbg = r_state;

   ram_addr_gen #(
      .AW        (AW),
      .MEM_DEPTH (MEM_DEPTH)
   ) u_scan_addr (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (scan_clr),
      .load     (1'b0),
      .load_val ('0),
      .en       (scan_issue),
      .count    (scan_cnt),
      .last     (scan_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= R_IDLE;
      end else begin
         r_state <= r_state_nxt;
      end
   end

   always_comb begin
      r_state_nxt = r_state;
      scan_clr    = 1'b0;
      scan_issue  = 1'b0;
      case (r_state)
         R_IDLE: begin
            if (rd_start) begin
               r_state_nxt = R_SCAN;
               scan_clr    = 1'b1;
            end
         end
         R_SCAN: begin
            if (rd_en) begin
               scan_issue = 1'b1;
               if (scan_last) begin
`ifdef RAMCTL_CONT_SCAN_EN
                  // Wrap straight into the next frame when asked to.
                  if (rd_start) begin
                     scan_clr = 1'b1;
                  end else begin
                     r_state_nxt = R_IDLE;
                  end
`else
                  r_state_nxt = R_IDLE;
`endif
               end
            end
         end
         default: r_state_nxt = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ram_regread  <= 1'b0;
         ram_addr_out <= '0;
         frame_pend   <= 1'b0;
         rd_valid     <= 1'b0;
         rd_frame_end <= 1'b0;
      end else begin
         ram_regread <= scan_issue;
         if (scan_issue) begin
            ram_addr_out <= scan_cnt;
         end
         // Two stages so the end-of-frame flag lines up with rd_valid,
         // which trails ram_regread by the RAM read latency.
         frame_pend   <= scan_issue && scan_last;
         rd_valid     <= ram_regread;
         rd_frame_end <= frame_pend;
      end
   end

   // Forced to 0 outside valid words so reset and idle show a clean bus.
   assign rd_data = rd_valid ? ram_data_out : '0;

endmodule

// File: doc/ram_dp_ctrl.md
Name: ram_dp_ctrl

Overview:
- Controller/arbiter in front of the dual-port frame buffer `buffer_ram_dp`: 16-bit data, 17-bit address, one write port (`addr_in`/`data_in`/`regwrite`), one read port (`addr_out`/`regread`/`data_out`).
- Write port is shared between an external pixel-capture requester and an internal clear (fill) engine.
- Read port is driven by a sequential scan engine feeding the display path.
- Sits between the capture/display logic and the RAM instance.

Parameters:
- AW, 17, address width.
- DW, 16, data width.
- MEM_DEPTH, 76800, number of valid words (320x240); addresses 0..MEM_DEPTH-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_req  in  1  capture write request.
- wr_addr  in  AW  capture write address.
- wr_data  in  DW  capture write data.
- wr_ready  out  1  write port can accept capture request this cycle.
- clr_start  in  1  start fill of whole memory.
- clr_color  in  DW  fill value, sampled when clr_start is accepted.
- clr_busy  out  1  fill in progress.
- clr_done  out  1  one-cycle pulse after last fill write.
- rd_start  in  1  start read scan.
- rd_en  in  1  scan advance enable (0 = stall).
- rd_valid  out  1  rd_data valid.
- rd_data  out  DW  scanned word.
- rd_frame_end  out  1  pulse coincident with rd_valid of last word.
- ram_addr_in  out  AW  to RAM write address.
- ram_data_in  out  DW  to RAM write data.
- ram_regwrite  out  1  to RAM write enable.
- ram_addr_out  out  AW  to RAM read address.
- ram_regread  out  1  to RAM read enable.
- ram_data_out  in  DW  from RAM, valid 1 cycle after regread.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, both FSMs idle, counters 0. Assertion mid-clear or mid-scan aborts immediately; no clr_done or rd_frame_end is issued.
- All RAM-side outputs are registered.

Write FSM, states W_IDLE and W_CLEAR:
- wr_ready = (state==W_IDLE) && !clr_start. Combinational, so clear has priority when both arrive in the same cycle.
- Capture accept: at the edge where wr_req && wr_ready. Next cycle: ram_regwrite=1, ram_addr_in=wr_addr, ram_data_in=wr_data. Throughput is 1 word per cycle.
- Capture wr_addr >= MEM_DEPTH: request is accepted (handshake completes), but no regwrite is issued.
- W_IDLE + clr_start: latch clr_color, counter=0, go to W_CLEAR, clr_busy=1 from the next cycle.
- W_CLEAR: writes counter address each cycle, 0..MEM_DEPTH-1, with regwrite=1. After address MEM_DEPTH-1 is written: clr_done=1 for 1 cycle, clr_busy=0, return to W_IDLE.
- clr_start during W_CLEAR is ignored.
- Capture requests are held off (wr_ready=0) for the whole clear.

Read FSM, states R_IDLE and R_SCAN:
- R_IDLE + rd_start: counter=0, go to R_SCAN.
- R_SCAN with rd_en=1: ram_regread=1, ram_addr_out=counter, counter increments.
- R_SCAN with rd_en=0: ram_regread=0, counter holds.
- rd_valid is ram_regread delayed 1 cycle; rd_data = ram_data_out.
- When address MEM_DEPTH-1 is issued, return to R_IDLE. rd_frame_end pulses with the final rd_valid.
- rd_start during R_SCAN is ignored.

Collisions and counters:
- Read and write FSMs run independently.
- Same-address read/write in one cycle: the RAM returns the old word; the controller takes no action.
- Counters never exceed MEM_DEPTH-1; no wrap-around without the optional feature.

Optional Feature:
- Macro: RAMCTL_CONT_SCAN_EN.
- Defined: on issuing address MEM_DEPTH-1, if rd_start=1 in that cycle the counter wraps to 0 and R_SCAN continues with no bubble; rd_frame_end still pulses each frame. If rd_start=0, go to R_IDLE.
- Undefined: scan always returns to R_IDLE after one frame.

Decomposition:
- Package ram_ctrl_pkg: AW, DW, MEM_DEPTH defaults and the state encodings W_IDLE/W_CLEAR and R_IDLE/R_SCAN.
- Sub-module ram_addr_gen: loadable up-counter with enable, clear-to-0 and last-address flag (count == MEM_DEPTH-1). Instantiated twice, once for clear and once for scan.

Test Plan (MEM_DEPTH=16 override):
- Reset release, then wr_req=1, wr_addr=5, wr_data=16'hABCD for 1 cycle -> next cycle ram_regwrite=1, ram_addr_in=5, ram_data_in=16'hABCD; then rd_start -> rd_data at index 5 = 16'hABCD.
- clr_start and wr_req asserted in the same cycle, clr_color=16'h00FF -> wr_ready=0; 16 consecutive writes at addresses 0..15 of 16'h00FF; clr_done pulses once; the capture write is then accepted.
- rd_start with rd_en toggling 1,0,1,0... -> addresses 0..15 issued in order with no duplicates; rd_valid exactly 16 times; rd_frame_end on the 16th.
- wr_addr=20 (out of range) -> wr_ready handshake completes, ram_regwrite stays 0.
- rst_n pulsed low at clear address 7 -> all outputs 0 immediately, no clr_done; after release a new clr_start restarts from address 0.
- With RAMCTL_CONT_SCAN_EN and rd_start held high -> address 15 is followed directly by 0; rd_frame_end every 16 rd_valid.
